// File: rtl/output_buffer_lsu.sv
// output_buffer_lsu
//   Output-peripheral register bank at 0x7000-0x703F behind the LSU store
//   decoder. Holds LEDR/LEDG, eight seven-segment patterns and an LCD
//   shadow register, all written with byte masks, and returns registered
//   read-back one cycle after the address is presented.
//
//   Optional feature macro: OUTBUF_LCD_EN
//     defined   : LCD writes are paced by an IDLE->SETUP->PULSE->HOLD FSM that
//                 drives EN; stores while busy are dropped and flagged in a
//                 sticky status bit at 0x34.
//     undefined : 0x30 is a plain register, EN is its bit 10, 0x34 reads 0,
//                 o_lcd_busy is tied low.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_st_en               store strobe
//   i_lsu_addr[15:0]      byte address (window re-checked here)
//   i_wr_op_data[31:0]    store data
//   i_bmask[3:0]          byte-lane write enables
//   o_ld_op_data[31:0]    registered read data
//   o_io_ledr/o_io_ledg   LED outputs (17 / 8 bits used)
//   o_io_hex0..7[6:0]     seven-segment patterns
//   o_io_lcd[31:0]        {ON, 20'b0, EN, RS, RW, data[7:0]}
//   o_lcd_busy            LCD FSM not idle
module output_buffer_lsu #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_st_en,
    input  logic [15:0] i_lsu_addr,
    input  logic [31:0] i_wr_op_data,
    input  logic [3:0]  i_bmask,
    output logic [31:0] o_ld_op_data,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7,
    output logic [31:0] o_io_lcd,
    output logic        o_lcd_busy
);

    localparam logic [9:0]  WINDOW   = 10'b0111_0000_00;
    localparam logic [31:0] LCD_MASK = 32'h8000_07FF;   // ON + EN/RS/RW + data

    localparam logic [3:0] OFF_LEDR = 4'h0;
    localparam logic [3:0] OFF_LEDG = 4'h4;
    localparam logic [3:0] OFF_HEXL = 4'h8;
    localparam logic [3:0] OFF_HEXH = 4'h9;
    localparam logic [3:0] OFF_LCD  = 4'hC;
    localparam logic [3:0] OFF_STAT = 4'hD;

    logic        hit;
    logic [3:0]  off;
    logic        wr_ok;
    logic [31:0] bmask32;

    logic [16:0] ledr_q;
    logic [7:0]  ledg_q;
    logic [6:0]  hex_q [8];
    logic [31:0] lcd_q;
    logic [31:0] lcd_merged;
    logic [31:0] stat_rd;
    logic [31:0] rd_mux;
    logic        unused_ok;

    assign hit        = (i_lsu_addr[15:6] == WINDOW);
    assign off        = i_lsu_addr[5:2];
    assign wr_ok      = i_st_en && hit;
    assign bmask32    = {{8{i_bmask[3]}}, {8{i_bmask[2]}}, {8{i_bmask[1]}}, {8{i_bmask[0]}}};
    assign lcd_merged = (lcd_q & ~(bmask32 & LCD_MASK)) | (i_wr_op_data & bmask32 & LCD_MASK);

    assign o_io_ledr = {15'b0, ledr_q};
    assign o_io_ledg = {24'b0, ledg_q};
    assign o_io_hex0 = hex_q[0];
    assign o_io_hex1 = hex_q[1];
    assign o_io_hex2 = hex_q[2];
    assign o_io_hex3 = hex_q[3];
    assign o_io_hex4 = hex_q[4];
    assign o_io_hex5 = hex_q[5];
    assign o_io_hex6 = hex_q[6];
    assign o_io_hex7 = hex_q[7];

    // LED and seven-segment registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ledr_q <= '0;
            ledg_q <= '0;
            for (int k = 0; k < 8; k++) hex_q[k] <= '0;
        end else begin
            if (wr_ok && off == OFF_LEDR)
                ledr_q <= (ledr_q & ~bmask32[16:0]) | (i_wr_op_data[16:0] & bmask32[16:0]);
            if (wr_ok && off == OFF_LEDG && i_bmask[0])
                ledg_q <= i_wr_op_data[7:0];
            for (int k = 0; k < 4; k++) begin
                if (wr_ok && i_bmask[k]) begin
                    if (off == OFF_HEXL) hex_q[k]   <= i_wr_op_data[8*k +: 7];
                    if (off == OFF_HEXH) hex_q[k+4] <= i_wr_op_data[8*k +: 7];
                end
            end
        end
    end

`ifdef OUTBUF_LCD_EN
    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} lcd_st_t;

    lcd_st_t     st_q;
    logic [15:0] cnt_q;
    logic        en_q;
    logic        busy_q;
    logic        drop_q;
    logic        lcd_st;
    logic        lcd_ready;
    logic        accept;
    logic        drop_ev;
    logic        clr_ev;

    // Ready one cycle early on the last HOLD cycle, so a store seen at the
    // edge where busy falls starts the next transaction back-to-back.
    assign lcd_ready = (st_q == IDLE) ||
                       (st_q == HOLD && cnt_q == 16'(HOLD_CYC - 1));
    assign lcd_st    = wr_ok && off == OFF_LCD && (|i_bmask);
    assign accept    = lcd_st && lcd_ready;
    assign drop_ev   = lcd_st && !lcd_ready;
    assign clr_ev    = wr_ok && off == OFF_STAT;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            drop_q <= 1'b0;
            lcd_q  <= '0;
        end else begin
            // set dominates clear
            if (drop_ev)     drop_q <= 1'b1;
            else if (clr_ev) drop_q <= 1'b0;

            if (accept) begin
                lcd_q  <= lcd_merged;
                st_q   <= SETUP;
                cnt_q  <= '0;
                en_q   <= 1'b0;
                busy_q <= 1'b1;
            end else begin
                case (st_q)
                    SETUP: begin
                        if (cnt_q == 16'(SETUP_CYC - 1)) begin
                            st_q  <= PULSE;
                            cnt_q <= '0;
                            en_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    PULSE: begin
                        if (cnt_q == 16'(PULSE_CYC - 1)) begin
                            st_q  <= HOLD;
                            cnt_q <= '0;
                            en_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    HOLD: begin
                        if (cnt_q == 16'(HOLD_CYC - 1)) begin
                            st_q   <= IDLE;
                            cnt_q  <= '0;
                            busy_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_io_lcd   = {lcd_q[31], 20'b0, en_q, lcd_q[9:0]};
    assign o_lcd_busy = busy_q;
    assign stat_rd    = {30'b0, drop_q, busy_q};
    assign unused_ok  = ^{i_lsu_addr[1:0], lcd_q[30:11]};
`else
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                    lcd_q <= '0;
        else if (wr_ok && off == OFF_LCD) lcd_q <= lcd_merged;
    end

    assign o_io_lcd   = lcd_q;
    assign o_lcd_busy = 1'b0;
    assign stat_rd    = 32'b0;
    assign unused_ok  = ^{i_lsu_addr[1:0], 32'(SETUP_CYC), 32'(PULSE_CYC), 32'(HOLD_CYC)};
`endif

    // Read mux sees pre-write register contents; result registered every cycle.
    always_comb begin
        rd_mux = 32'b0;
        if (hit) begin
            case (off)
                OFF_LEDR: rd_mux = {15'b0, ledr_q};
                OFF_LEDG: rd_mux = {24'b0, ledg_q};
                OFF_HEXL: rd_mux = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
                OFF_HEXH: rd_mux = {1'b0, hex_q[7], 1'b0, hex_q[6], 1'b0, hex_q[5], 1'b0, hex_q[4]};
                OFF_LCD:  rd_mux = lcd_q;
                OFF_STAT: rd_mux = stat_rd;
                default:  rd_mux = 32'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_ld_op_data <= '0;
        else       o_ld_op_data <= rd_mux;
    end

endmodule
